// File: rtl/data_memory_quad_port_pkg.sv
// Shared constants for the quad-port data memory and the blocks around it.
// The default geometry is 256 words of 16 bits behind 16-bit addresses.
package data_memory_quad_port_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int DEPTH     = 256;
    localparam int NUM_PORTS = 4;

endpackage

// File: rtl/data_memory_write_arbiter.sv
// Qualifies each port's write enable.
// A write survives only if its address is in range and no lower-index port writes the same address this cycle.
module data_memory_write_arbiter
    import data_memory_quad_port_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int DEPTH_P  = DEPTH
) (
    input  logic [NUM_PORTS-1:0] we,
    input  logic [ADDR_W_P-1:0]  addr [NUM_PORTS],
    output logic [NUM_PORTS-1:0] we_qual
);

    logic [NUM_PORTS-1:0] in_range;

    // Port 0 has nothing above it; every later port is masked by any lower port writing the same word.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign in_range[p] = (addr[p] < ADDR_W_P'(DEPTH_P));

        if (p == 0) begin : g_first
            assign we_qual[p] = we[p] && in_range[p];
        end else begin : g_masked
            logic blocked;

            always_comb begin
                blocked = 1'b0;
                for (int q = 0; q < p; q++) begin
                    if (we[q] && in_range[q] && (addr[q] == addr[p])) begin
                        blocked = 1'b1;
                    end
                end
            end

            assign we_qual[p] = we[p] && in_range[p] && !blocked;
        end
    end

endmodule

// File: rtl/data_memory_quad_port.sv
// Four-port shared data memory: one read/write port per core, read-first, one-cycle read latency.
// Out-of-range addresses neither write nor alias; they read back as zero.
module data_memory_quad_port
    import data_memory_quad_port_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int DEPTH_P  = DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W_P-1:0] data_in_1,
    input  logic [DATA_W_P-1:0] data_in_2,
    input  logic [DATA_W_P-1:0] data_in_3,
    input  logic [DATA_W_P-1:0] data_in_4,
    input  logic [ADDR_W_P-1:0] addr_1,
    input  logic [ADDR_W_P-1:0] addr_2,
    input  logic [ADDR_W_P-1:0] addr_3,
    input  logic [ADDR_W_P-1:0] addr_4,
    input  logic                we_1,
    input  logic                we_2,
    input  logic                we_3,
    input  logic                we_4,
    output logic [DATA_W_P-1:0] data_out_1,
    output logic [DATA_W_P-1:0] data_out_2,
    output logic [DATA_W_P-1:0] data_out_3,
    output logic [DATA_W_P-1:0] data_out_4
);

    localparam int IDX_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;

    logic [DATA_W_P-1:0] mem [DEPTH_P];
    logic [DATA_W_P-1:0] wdata [NUM_PORTS];
    logic [ADDR_W_P-1:0] addr [NUM_PORTS];
    logic [DATA_W_P-1:0] rdata [NUM_PORTS];
    logic [NUM_PORTS-1:0] we;
    logic [NUM_PORTS-1:0] we_qual;

    assign wdata = '{data_in_1, data_in_2, data_in_3, data_in_4};
    assign addr  = '{addr_1, addr_2, addr_3, addr_4};
    assign we    = {we_4, we_3, we_2, we_1};

    data_memory_write_arbiter #(
        .ADDR_W_P (ADDR_W_P),
        .DEPTH_P  (DEPTH_P)
    ) u_arbiter (
        .we      (we),
        .addr    (addr),
        .we_qual (we_qual)
    );

    // The arbiter guarantees at most one qualified writer per word, so port order here is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_P; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (we_qual[p]) begin
                    mem[addr[p][IDX_W-1:0]] <= wdata[p];
                end
            end
        end
    end

    // Reads sample the array before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rdata[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (addr[p] < ADDR_W_P'(DEPTH_P)) begin
                    rdata[p] <= mem[addr[p][IDX_W-1:0]];
                end else begin
                    rdata[p] <= '0;
                end
            end
        end
    end

    assign data_out_1 = rdata[0];
    assign data_out_2 = rdata[1];
    assign data_out_3 = rdata[2];
    assign data_out_4 = rdata[3];

endmodule

// File: tb/tb_data_memory_quad_port.sv
// Directed plus light random bench for the quad-port memory, checked against a
// behavioural model through an expected-value queue.
module tb_data_memory_quad_port;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in_1, data_in_2, data_in_3, data_in_4;
    logic [AW-1:0] addr_1, addr_2, addr_3, addr_4;
    logic          we_1, we_2, we_3, we_4;
    logic [DW-1:0] data_out_1, data_out_2, data_out_3, data_out_4;

    logic [DW-1:0] dout [4];
    logic          st_we [4];
    logic [AW-1:0] st_addr [4];
    logic [DW-1:0] st_din [4];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    string         cur_tag;
    int            vectors;
    int            miscompares;

    data_memory_quad_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in_1  (data_in_1),
        .data_in_2  (data_in_2),
        .data_in_3  (data_in_3),
        .data_in_4  (data_in_4),
        .addr_1     (addr_1),
        .addr_2     (addr_2),
        .addr_3     (addr_3),
        .addr_4     (addr_4),
        .we_1       (we_1),
        .we_2       (we_2),
        .we_3       (we_3),
        .we_4       (we_4),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .data_out_3 (data_out_3),
        .data_out_4 (data_out_4)
    );

    assign dout = '{data_out_1, data_out_2, data_out_3, data_out_4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input int port, input logic [DW-1:0] observed,
                           input logic [DW-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s port%0d: observed %h expected %h", tag, port + 1, observed, expected);
        end
    endtask

    task automatic idle_ports();
        for (int p = 0; p < 4; p++) begin
            st_we[p]   = 1'b0;
            st_addr[p] = '0;
            st_din[p]  = '0;
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_we[p]   = w;
        st_addr[p] = a;
        st_din[p]  = d;
    endtask

    task automatic checkOutput();
        logic [DW-1:0] exp;
        for (int p = 0; p < 4; p++) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL %s port%0d: observed %h expected <empty scoreboard>", cur_tag, p + 1, dout[p]);
            end else begin
                exp = exp_q.pop_front();
                compare(cur_tag, p, dout[p], exp);
            end
        end
    endtask

    // Drives one cycle, predicts read-first results, then applies writes to the model with port 1 winning.
    task automatic applyStimulus(input string tag);
        @(negedge clk);
        cur_tag   = tag;
        we_1 = st_we[0];   we_2 = st_we[1];   we_3 = st_we[2];   we_4 = st_we[3];
        addr_1 = st_addr[0]; addr_2 = st_addr[1]; addr_3 = st_addr[2]; addr_4 = st_addr[3];
        data_in_1 = st_din[0]; data_in_2 = st_din[1]; data_in_3 = st_din[2]; data_in_4 = st_din[3];
        for (int p = 0; p < 4; p++) begin
            if (int'(st_addr[p]) < DEPTH) exp_q.push_back(model[int'(st_addr[p])]);
            else                          exp_q.push_back('0);
        end
        for (int p = 3; p >= 0; p--) begin
            if (st_we[p] && int'(st_addr[p]) < DEPTH) model[int'(st_addr[p])] = st_din[p];
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        idle_ports();
        we_1 = 0; we_2 = 0; we_3 = 0; we_4 = 0;
        addr_1 = 0; addr_2 = 0; addr_3 = 0; addr_4 = 0;
        data_in_1 = 0; data_in_2 = 0; data_in_3 = 0; data_in_4 = 0;
        rst_n = 1'b0;
        #23;
        for (int p = 0; p < 4; p++) compare("reset_init", p, dout[p], '0);
        @(negedge clk);
        rst_n = 1'b1;

        idle_ports();
        applyStimulus("idle_read0");

        idle_ports();
        set_port(0, 1'b1, 16'd10, 16'd1);
        applyStimulus("single_write");
        idle_ports();
        set_port(1, 1'b0, 16'd10, 16'd0);
        applyStimulus("single_readback");

        idle_ports();
        set_port(0, 1'b1, 16'd10, 16'd1);
        set_port(1, 1'b1, 16'd20, 16'd2);
        set_port(2, 1'b1, 16'd30, 16'd3);
        set_port(3, 1'b1, 16'd40, 16'd4);
        applyStimulus("quad_write");
        idle_ports();
        set_port(0, 1'b0, 16'd20, 16'd0);
        set_port(1, 1'b0, 16'd20, 16'd0);
        set_port(2, 1'b0, 16'd30, 16'd0);
        set_port(3, 1'b0, 16'd40, 16'd0);
        applyStimulus("quad_read");

        idle_ports();
        set_port(0, 1'b1, 16'd7, 16'd5);
        set_port(1, 1'b0, 16'd7, 16'd0);
        set_port(2, 1'b1, 16'd7, 16'd9);
        set_port(3, 1'b0, 16'd7, 16'd0);
        applyStimulus("conflict_write");
        idle_ports();
        for (int p = 0; p < 4; p++) set_port(p, 1'b0, 16'd7, 16'd0);
        applyStimulus("conflict_read");

        idle_ports();
        set_port(1, 1'b1, 16'd8, 16'h0BBB);
        set_port(2, 1'b1, 16'd8, 16'h0CCC);
        set_port(3, 1'b1, 16'd8, 16'h0DDD);
        applyStimulus("conflict_p2_wins");
        idle_ports();
        set_port(3, 1'b0, 16'd8, 16'd0);
        applyStimulus("conflict_p2_read");

        idle_ports();
        set_port(0, 1'b1, 16'd50, 16'h0011);
        applyStimulus("rdw_setup");
        idle_ports();
        set_port(0, 1'b1, 16'd50, 16'h0022);
        set_port(1, 1'b0, 16'd50, 16'd0);
        applyStimulus("read_during_write");
        idle_ports();
        set_port(1, 1'b0, 16'd50, 16'd0);
        applyStimulus("rdw_after");

        idle_ports();
        set_port(0, 1'b1, 16'd44, 16'h4444);
        set_port(1, 1'b1, 16'd255, 16'hF0F0);
        applyStimulus("oor_setup");
        idle_ports();
        set_port(0, 1'b1, 16'd300, 16'hABCD);
        set_port(1, 1'b1, 16'd256, 16'h1234);
        set_port(2, 1'b0, 16'd255, 16'd0);
        applyStimulus("oor_write");
        idle_ports();
        set_port(0, 1'b0, 16'd300, 16'd0);
        set_port(1, 1'b0, 16'd44, 16'd0);
        set_port(2, 1'b0, 16'd0, 16'd0);
        set_port(3, 1'b0, 16'd255, 16'd0);
        applyStimulus("oor_read");

        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 4; p++) begin
                set_port(p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15) + ((n % 3 == 0) ? 250 : 0)),
                         16'($urandom));
            end
            applyStimulus("random");
        end

        // Asynchronous reset dropped between edges must clear outputs without waiting for a clock.
        idle_ports();
        for (int p = 0; p < 4; p++) set_port(p, 1'b0, 16'(10 * (p + 1)), 16'd0);
        applyStimulus("pre_reset_read");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) compare("async_reset", p, dout[p], '0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_ports();
        set_port(0, 1'b0, 16'd10, 16'd0);
        set_port(1, 1'b0, 16'd20, 16'd0);
        set_port(2, 1'b0, 16'd50, 16'd0);
        set_port(3, 1'b0, 16'd255, 16'd0);
        applyStimulus("post_reset_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
